// File: rtl/golf_ball_engine_if.sv
// Signal bundle between the golf engine and its neighbours: the frame/button
// and collision inputs from the VGA timing / ROM lookup side, and the ball
// state consumed by the pixel colour mux.
interface golf_ball_engine_if #(
  parameter int VEL_W = 10
);
  logic                    frame_tick;
  logic                    shoot;
  logic                    new_game;
  logic signed [VEL_W-1:0] aim_x;
  logic signed [VEL_W-1:0] aim_y;
  logic                    coll_x;
  logic                    coll_y;
  logic [9:0]              ball_x;
  logic [9:0]              ball_y;
  logic                    ball_idle;
  logic                    victory;
  logic [7:0]              stroke_cnt;

  modport master (
    output frame_tick, shoot, new_game, aim_x, aim_y, coll_x, coll_y,
    input  ball_x, ball_y, ball_idle, victory, stroke_cnt
  );

  modport slave (
    input  frame_tick, shoot, new_game, aim_x, aim_y, coll_x, coll_y,
    output ball_x, ball_y, ball_idle, victory, stroke_cnt
  );
endinterface

// File: rtl/golf_ball_engine.sv
// Per-frame golf ball physics and game state: fixed-point position/velocity,
// shot latching, wall bounce, friction, slow zone around the hole and win
// detection, with an AIM/ROLL/WIN state machine.
module golf_ball_engine #(
  parameter int H_RES           = 800,
  parameter int V_RES           = 600,
  parameter int FRAC            = 4,
  parameter int VEL_W           = 10,
  parameter int MAX_SPEED       = 127,
  parameter int FRICTION        = 1,
  parameter int FRICTION_PERIOD = 5,
  parameter int START_X         = 400,
  parameter int START_Y         = 500,
  parameter int FINISH_X        = 400,
  parameter int FINISH_Y        = 80,
  parameter int SLOW_R2         = 144,
  parameter int WIN_R2          = 400,
  parameter int WIN_SPEED2      = 576
) (
  input logic               pixel_clk,
  input logic               rst_n,
  golf_ball_engine_if.slave bus
);
  localparam int PW   = 10 + FRAC;
  localparam int SW   = 11 + FRAC;
  localparam int VQ_W = 2 * VEL_W + 1;
  localparam int FC_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;

  localparam logic [PW-1:0]            X_START   = PW'(START_X << FRAC);
  localparam logic [PW-1:0]            Y_START   = PW'(START_Y << FRAC);
  localparam logic [PW-1:0]            X_MAX     = PW'((H_RES - 1) << FRAC);
  localparam logic [PW-1:0]            Y_MAX     = PW'((V_RES - 1) << FRAC);
  localparam logic signed [VEL_W-1:0]  MAX_V     = VEL_W'(MAX_SPEED);
  localparam logic signed [VEL_W-1:0]  FRIC_V    = VEL_W'(FRICTION);
  localparam logic [FC_W-1:0]          FC_LAST   = FC_W'(FRICTION_PERIOD - 1);
  localparam logic signed [10:0]       FIN_X     = 11'(FINISH_X);
  localparam logic signed [10:0]       FIN_Y     = 11'(FINISH_Y);
  localparam logic [21:0]              SLOW_LIM  = 22'(SLOW_R2);
  localparam logic [21:0]              WIN_LIM   = 22'(WIN_R2);
  localparam logic [VQ_W-1:0]          SPEED_LIM = VQ_W'(WIN_SPEED2);

  // ROLL=00 so that bit 0 is the idle flag and bit 1 the victory flag,
  // letting both outputs come straight off state flops.
  typedef enum logic [1:0] {
    ROLL = 2'b00,
    AIM  = 2'b01,
    WIN  = 2'b10
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [VEL_W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [7:0]              stroke_q, stroke_d;
  logic [FC_W-1:0]         frame_cnt_q, frame_cnt_d;
  logic                    shot_pending_q, shot_pending_d;
  logic                    shoot_prev_q;

  logic                    shot_edge, fric_tick, in_slow, win_hit;
  logic signed [VEL_W-1:0] vx_c, vy_c, vx_m, vy_m, vx_f, vy_f, vx_s, vy_s;
  logic [PW:0]             mv_x, mv_y;
  logic [21:0]             d2;

  function automatic logic signed [VEL_W-1:0] friction_step(input logic signed [VEL_W-1:0] v);
    if ((v <= FRIC_V) && (v >= -FRIC_V)) return '0;
    else if (!v[VEL_W-1])                return v - FRIC_V;
    else                                 return v + FRIC_V;
  endfunction

  function automatic logic signed [VEL_W-1:0] clamp_aim(input logic signed [VEL_W-1:0] a);
    if (a > MAX_V)       return MAX_V;
    else if (a < -MAX_V) return -MAX_V;
    else                 return a;
  endfunction

  // Returns {bounced, new_position}; bounced means the edge clamp engaged.
  function automatic logic [PW:0] axis_move(input logic [PW-1:0] pos,
                                            input logic signed [VEL_W-1:0] vel,
                                            input logic [PW-1:0] pmax);
    logic signed [SW-1:0] sum;
    sum = $signed({1'b0, pos}) + SW'(vel);
    if (sum[SW-1])                        return {1'b1, {PW{1'b0}}};
    else if (sum > $signed({1'b0, pmax})) return {1'b1, pmax};
    else                                  return {1'b0, sum[PW-1:0]};
  endfunction

  function automatic logic [21:0] dist2(input logic [9:0] px, input logic [9:0] py);
    logic signed [10:0] dx, dy;
    logic signed [21:0] dx2, dy2;
    dx  = $signed({1'b0, px}) - FIN_X;
    dy  = $signed({1'b0, py}) - FIN_Y;
    dx2 = 22'(dx) * 22'(dx);
    dy2 = 22'(dy) * 22'(dy);
    return $unsigned(dx2) + $unsigned(dy2);
  endfunction

  function automatic logic [VQ_W-1:0] speed2(input logic signed [VEL_W-1:0] vx,
                                             input logic signed [VEL_W-1:0] vy);
    logic signed [VQ_W-1:0] x2, y2;
    x2 = VQ_W'(vx) * VQ_W'(vx);
    y2 = VQ_W'(vy) * VQ_W'(vy);
    return $unsigned(x2) + $unsigned(y2);
  endfunction

  // One frame of rolling physics: wall flip, move with edge bounce, periodic
  // friction, slow-zone friction, then the win test on the moved position.
  always_comb begin
    shot_edge = bus.shoot & ~shoot_prev_q;
    fric_tick = (frame_cnt_q == '0);
    vx_c      = bus.coll_x ? -vel_x_q : vel_x_q;
    vy_c      = bus.coll_y ? -vel_y_q : vel_y_q;
    mv_x      = axis_move(pos_x_q, vx_c, X_MAX);
    mv_y      = axis_move(pos_y_q, vy_c, Y_MAX);
    vx_m      = mv_x[PW] ? -vx_c : vx_c;
    vy_m      = mv_y[PW] ? -vy_c : vy_c;
    vx_f      = fric_tick ? friction_step(vx_m) : vx_m;
    vy_f      = fric_tick ? friction_step(vy_m) : vy_m;
    d2        = dist2(mv_x[PW-1:FRAC], mv_y[PW-1:FRAC]);
    in_slow   = (d2 < SLOW_LIM);
    vx_s      = in_slow ? friction_step(vx_f) : vx_f;
    vy_s      = in_slow ? friction_step(vy_f) : vy_f;
    win_hit   = (d2 < WIN_LIM) && (speed2(vx_s, vy_s) < SPEED_LIM);
  end

  // Next-state logic; new_game overrides everything else in the cycle.
  always_comb begin
    state_d        = state_q;
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    vel_x_d        = vel_x_q;
    vel_y_d        = vel_y_q;
    stroke_d       = stroke_q;
    frame_cnt_d    = frame_cnt_q;
    shot_pending_d = shot_pending_q;

    if (bus.new_game) begin
      state_d        = AIM;
      pos_x_d        = X_START;
      pos_y_d        = Y_START;
      vel_x_d        = '0;
      vel_y_d        = '0;
      stroke_d       = '0;
      frame_cnt_d    = '0;
      shot_pending_d = 1'b0;
    end else begin
      if (bus.frame_tick)
        frame_cnt_d = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + 1'b1;
      case (state_q)
        AIM: begin
          if (shot_edge)
            shot_pending_d = 1'b1;
          if (bus.frame_tick && shot_pending_q) begin
            vel_x_d        = clamp_aim(bus.aim_x);
            vel_y_d        = clamp_aim(bus.aim_y);
            stroke_d       = (stroke_q == 8'hFF) ? stroke_q : stroke_q + 8'd1;
            shot_pending_d = 1'b0;
            state_d        = ROLL;
          end
        end
        ROLL: begin
          if (bus.frame_tick) begin
            pos_x_d = mv_x[PW-1:0];
            pos_y_d = mv_y[PW-1:0];
            if (win_hit) begin
              vel_x_d = '0;
              vel_y_d = '0;
              state_d = WIN;
            end else begin
              vel_x_d = vx_s;
              vel_y_d = vy_s;
              if ((vx_s == '0) && (vy_s == '0))
                state_d = AIM;
            end
          end
        end
        WIN:     state_d = WIN;
        default: state_d = AIM;
      endcase
    end
  end

  // State and datapath registers; shoot history is sampled every cycle.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= AIM;
      pos_x_q        <= X_START;
      pos_y_q        <= Y_START;
      vel_x_q        <= '0;
      vel_y_q        <= '0;
      stroke_q       <= '0;
      frame_cnt_q    <= '0;
      shot_pending_q <= 1'b0;
      shoot_prev_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      vel_x_q        <= vel_x_d;
      vel_y_q        <= vel_y_d;
      stroke_q       <= stroke_d;
      frame_cnt_q    <= frame_cnt_d;
      shot_pending_q <= shot_pending_d;
      shoot_prev_q   <= bus.shoot;
    end
  end

  assign bus.ball_x     = pos_x_q[PW-1:FRAC];
  assign bus.ball_y     = pos_y_q[PW-1:FRAC];
  assign bus.ball_idle  = state_q[0];
  assign bus.victory    = state_q[1];
  assign bus.stroke_cnt = stroke_q;
endmodule

// File: tb/tb_golf_ball_engine.sv
// Directed bench for golf_ball_engine: reset, launch latency, wall flips,
// edge clamp/bounce, friction decay, slow zone, win, restart and stroke
// saturation, all against hand-computed positions.
module tb_golf_ball_engine;
  logic pixel_clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  golf_ball_engine_if #(.VEL_W(10)) bus ();

  golf_ball_engine dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  // Free-running pixel clock, 10 time units per period.
  always #5 pixel_clk = ~pixel_clk;

  // Drive one cycle of inputs, then wait past the next rising edge.
  task automatic applyStimulus(input logic tick, input logic shot, input logic ng,
                               input logic cx, input logic cy);
    bus.frame_tick = tick;
    bus.shoot      = shot;
    bus.new_game   = ng;
    bus.coll_x     = cx;
    bus.coll_y     = cy;
    @(posedge pixel_clk);
    #1;
  endtask

  // Compare every engine output against the expected values.
  task automatic checkOutput(input string tag, input int exp_x, input int exp_y,
                             input logic exp_idle, input logic exp_vic, input int exp_stroke);
    checks++;
    assert (bus.ball_x === 10'(exp_x)) else begin
      errors++;
      $error("[TB] FAIL %s ball_x observed %0d expected %0d", tag, bus.ball_x, exp_x);
    end
    checks++;
    assert (bus.ball_y === 10'(exp_y)) else begin
      errors++;
      $error("[TB] FAIL %s ball_y observed %0d expected %0d", tag, bus.ball_y, exp_y);
    end
    checks++;
    assert (bus.ball_idle === exp_idle) else begin
      errors++;
      $error("[TB] FAIL %s ball_idle observed %0b expected %0b", tag, bus.ball_idle, exp_idle);
    end
    checks++;
    assert (bus.victory === exp_vic) else begin
      errors++;
      $error("[TB] FAIL %s victory observed %0b expected %0b", tag, bus.victory, exp_vic);
    end
    checks++;
    assert (bus.stroke_cnt === 8'(exp_stroke)) else begin
      errors++;
      $error("[TB] FAIL %s stroke_cnt observed %0d expected %0d", tag, bus.stroke_cnt, exp_stroke);
    end
  endtask

  // Linear sequence of directed scenarios.
  initial begin
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.shoot      = 1'b0;
    bus.new_game   = 1'b0;
    bus.coll_x     = 1'b0;
    bus.coll_y     = 1'b0;
    bus.aim_x      = '0;
    bus.aim_y      = '0;
    repeat (3) @(posedge pixel_clk);
    #1;
    checkOutput("reset", 400, 500, 1'b1, 1'b0, 0);
    rst_n = 1'b1;

    $display("[TB] launch latency and wall flips");
    bus.aim_x = 10'sd32;
    bus.aim_y = -10'sd16;
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("shot_pending", 400, 500, 1'b1, 1'b0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("launch", 400, 500, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("first_move", 402, 499, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("coll_x_flip", 400, 498, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("coll_y_flip", 398, 499, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("restart_over_tick", 400, 500, 1'b1, 1'b0, 0);

    $display("[TB] friction decay to rest");
    bus.aim_x = 10'sd20;
    bus.aim_y = 10'sd0;
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("decay_launch", 400, 500, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("decay_coll_x", 398, 500, 1'b0, 1'b0, 1);
    repeat (4) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("decay_first_fric", 393, 500, 1'b0, 1'b0, 1);
    repeat (94) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("decay_last_roll", 334, 500, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("decay_rest", 334, 500, 1'b1, 1'b0, 1);

    $display("[TB] speed clamp and right edge bounce");
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("new_game_idle", 400, 500, 1'b1, 1'b0, 0);
    bus.aim_x = 10'sd300;
    bus.aim_y = 10'sd0;
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("clamp_launch", 400, 500, 1'b0, 1'b0, 1);
    repeat (5) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("clamp_speed", 439, 500, 1'b0, 1'b0, 1);
    repeat (47) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("edge_approach", 797, 500, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("edge_clamp", 799, 500, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("edge_bounce", 791, 500, 1'b0, 1'b0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 400, 500, 1'b1, 1'b0, 0);
    #2;
    rst_n = 1'b1;

    $display("[TB] slow zone crossing");
    bus.aim_x = 10'sd0;
    bus.aim_y = -10'sd300;
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (5) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("up_speed", 400, 460, 1'b0, 1'b0, 1);
    repeat (49) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("slow_enter", 400, 87, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("slow_centre", 400, 80, 1'b0, 1'b0, 1);
    repeat (3) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("slow_after_a", 400, 59, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("slow_after_b", 400, 52, 1'b0, 1'b0, 1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("restart_roll", 400, 500, 1'b1, 1'b0, 0);

    $display("[TB] slow approach and win");
    bus.aim_y = -10'sd51;
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (5) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("win_path", 400, 484, 1'b0, 1'b0, 1);
    repeat (204) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("win_outside", 400, 100, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("win_hit", 400, 99, 1'b0, 1'b1, 1);
    applyStimulus(1, 1, 0, 1, 1);
    checkOutput("win_frozen_a", 400, 99, 1'b0, 1'b1, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("win_frozen_b", 400, 99, 1'b0, 1'b1, 1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("restart_win", 400, 500, 1'b1, 1'b0, 0);

    $display("[TB] shot on tick and stroke saturation");
    bus.aim_x = 10'sd0;
    bus.aim_y = 10'sd0;
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("shot_with_tick", 400, 500, 1'b1, 1'b0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("shot_next_tick", 400, 500, 1'b0, 1'b0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("zero_roll_stop", 400, 500, 1'b1, 1'b0, 1);
    repeat (254) begin
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
    end
    checkOutput("stroke_255", 400, 500, 1'b1, 1'b0, 255);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("stroke_sat", 400, 500, 1'b1, 1'b0, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
